// File: rtl/kanagawa_fifo_pkg.sv
// Shared helpers for the kanagawa FIFO family: counter sizing and
// modulo pointer advance for rings whose slot count need not be a power of two.
package kanagawa_fifo_pkg;

    function automatic int fifo_count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned fifo_ptr_next(input int unsigned ptr, input int unsigned slots);
        return (ptr + 32'd1 >= slots) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/kanagawa_register_fifo_ring.sv
// Register-based circular overflow ring behind the head register.
// dout always presents the oldest ring entry; the caller tracks occupancy.
module kanagawa_register_fifo_ring
    import kanagawa_fifo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLOTS = 3
)(
    input  logic             clock,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int PTR_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    logic [WIDTH-1:0] mem [SLOTS];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Explicit compare-and-wrap; with a single slot both pointers stay at 0.
    always_ff @(posedge clock) begin
        if (!rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= PTR_W'(fifo_ptr_next(32'(wr_ptr), SLOTS));
            if (pop)
                rd_ptr <= PTR_W'(fifo_ptr_next(32'(rd_ptr), SLOTS));
        end
    end

    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/kanagawa_register_fifo_skid_deep.sv
// Deep register skid FIFO: register head drives q, DEPTH-1 entry ring behind it.
// All status outputs are registered from next-state count; control uses private copies.
module kanagawa_register_fifo_skid_deep
    import kanagawa_fifo_pkg::*;
#(
    parameter int WIDTH             = 32,
    parameter int DEPTH             = 4,
    parameter int ALMOST_FULL_LEVEL = DEPTH - 1,
    localparam int CNT_W            = fifo_count_width(DEPTH)
)(
    input  logic             clock,
    input  logic             rst,
    input  logic             clear,
    input  logic             wrreq,
    input  logic [WIDTH-1:0] data,
    output logic             full,
    output logic             almost_full,
    input  logic             rdreq,
    output logic             empty,
    output logic [WIDTH-1:0] q,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt;
    logic             empty_r;
    logic             full_r;
    logic             ring_empty;
    logic             head_from_data;
    logic             ring_push;
    logic             ring_pop;
    logic [WIDTH-1:0] ring_dout;

    assign ring_empty = (cnt_r <= CNT_W'(1));

    // A write bypasses the ring only when nothing older can still be ahead of it.
    always_comb begin
        head_from_data = wrreq && (empty_r || (rdreq && ring_empty));
        ring_push      = wrreq && !head_from_data;
        ring_pop       = rdreq && !ring_empty;
        cnt_nxt        = cnt_r;
        if (wrreq && !rdreq)
            cnt_nxt = cnt_r + CNT_W'(1);
        else if (rdreq && !wrreq)
            cnt_nxt = cnt_r - CNT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (!rst || clear) begin
            cnt_r       <= '0;
            count       <= '0;
            empty_r     <= 1'b1;
            empty       <= 1'b1;
            full_r      <= 1'b0;
            full        <= 1'b0;
            almost_full <= (ALMOST_FULL_LEVEL == 0);
        end else begin
            cnt_r       <= cnt_nxt;
            count       <= cnt_nxt;
            empty_r     <= (cnt_nxt == '0);
            empty       <= (cnt_nxt == '0);
            full_r      <= (cnt_nxt == CNT_W'(DEPTH));
            full        <= (cnt_nxt == CNT_W'(DEPTH));
            almost_full <= (cnt_nxt >= CNT_W'(ALMOST_FULL_LEVEL));
        end
    end

    always_ff @(posedge clock) begin
        if (ring_pop)
            q <= ring_dout;
        else if (head_from_data)
            q <= data;
    end

    kanagawa_register_fifo_ring #(
        .WIDTH (WIDTH),
        .SLOTS (DEPTH - 1)
    ) u_ring (
        .clock (clock),
        .rst   (rst),
        .clear (clear),
        .push  (ring_push),
        .pop   (ring_pop),
        .din   (data),
        .dout  (ring_dout)
    );

`ifndef NO_DYNAMIC_ASSERTS
    always_ff @(posedge clock) begin
        if (rst) begin
            assert (!(wrreq && full_r)) else $error("%m overflow");
            assert (!(rdreq && empty_r)) else $error("%m underflow");
            assert (count == cnt_r && empty == empty_r && full == full_r)
                else $error("%m flag copies diverged");
            assert (cnt_r <= CNT_W'(DEPTH)) else $error("%m count exceeds depth");
            assert (empty_r == (cnt_r == '0)) else $error("%m empty inconsistent");
            assert (full_r == (cnt_r == CNT_W'(DEPTH))) else $error("%m full inconsistent");
        end
    end
`endif

endmodule

// File: tb/tb_kanagawa_register_fifo_skid_deep.sv
// Directed plus random scoreboard bench for the deep register skid FIFO
// at DEPTH 4, 2 and 5.
module tb_kanagawa_register_fifo_skid_deep;

    logic clock = 1'b0;
    logic rst;
    logic clear;

    logic        wr4, rd4, full4, af4, empty4;
    logic [31:0] d4, q4;
    logic [2:0]  cnt4;

    logic        wr2, rd2, full2, af2, empty2;
    logic [15:0] d2, q2;
    logic [1:0]  cnt2;

    logic        wr5, rd5, full5, af5, empty5;
    logic [15:0] d5, q5;
    logic [2:0]  cnt5;

    logic [31:0] sb4[$];
    logic [15:0] sb2[$];
    logic [15:0] sb5[$];

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    kanagawa_register_fifo_skid_deep #(
        .WIDTH(32), .DEPTH(4), .ALMOST_FULL_LEVEL(3)
    ) u_d4 (
        .clock(clock), .rst(rst), .clear(clear), .wrreq(wr4), .data(d4),
        .full(full4), .almost_full(af4), .rdreq(rd4), .empty(empty4),
        .q(q4), .count(cnt4)
    );

    kanagawa_register_fifo_skid_deep #(
        .WIDTH(16), .DEPTH(2), .ALMOST_FULL_LEVEL(1)
    ) u_d2 (
        .clock(clock), .rst(rst), .clear(clear), .wrreq(wr2), .data(d2),
        .full(full2), .almost_full(af2), .rdreq(rd2), .empty(empty2),
        .q(q2), .count(cnt2)
    );

    kanagawa_register_fifo_skid_deep #(
        .WIDTH(16), .DEPTH(5), .ALMOST_FULL_LEVEL(2)
    ) u_d5 (
        .clock(clock), .rst(rst), .clear(clear), .wrreq(wr5), .data(d5),
        .full(full5), .almost_full(af5), .rdreq(rd5), .empty(empty5),
        .q(q5), .count(cnt5)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        rst = 1'b0; clear = 1'b0;
        wr4 = 1'b0; rd4 = 1'b0; d4 = '0;
        wr2 = 1'b0; rd2 = 1'b0; d2 = '0;
        wr5 = 1'b0; rd5 = 1'b0; d5 = '0;
        tick();
        rst = 1'b1;
        tick();
        check("rst_empty", empty4, 1);
        check("rst_full", full4, 0);
        check("rst_count", cnt4, 0);
        check("rst_af", af4, 0);

        // fill to full
        for (int i = 0; i < 4; i++) begin
            wr4 = 1'b1; d4 = 32'hA1 + 32'(i);
            sb4.push_back(d4);
            tick();
            check("fill_count", cnt4, i + 1);
            check("fill_af", af4, (i + 1 >= 3));
            check("fill_full", full4, (i == 3));
            check("fill_q", q4, 32'hA1);
        end
        wr4 = 1'b0;

        // drain
        for (int i = 0; i < 4; i++) begin
            rd4 = 1'b1;
            check("drain_q", q4, sb4.pop_front());
            tick();
        end
        rd4 = 1'b0;
        check("drain_empty", empty4, 1);
        check("drain_count", cnt4, 0);

        // steady state push+pop across ring wraps
        for (int i = 0; i < 2; i++) begin
            wr4 = 1'b1; d4 = 32'hB1 + 32'(i);
            sb4.push_back(d4);
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            wr4 = 1'b1; rd4 = 1'b1; d4 = 32'hB3 + 32'(i);
            check("flow_q", q4, sb4.pop_front());
            sb4.push_back(d4);
            tick();
            check("flow_count", cnt4, 2);
        end
        wr4 = 1'b0; rd4 = 1'b0;
        check("flow_q_after", q4, sb4[0]);

        // clear discards a same-cycle write
        wr4 = 1'b1; d4 = 32'hC0;
        tick();
        check("pre_clear_count", cnt4, 3);
        clear = 1'b1; d4 = 32'hEE;
        tick();
        clear = 1'b0; wr4 = 1'b0;
        sb4.delete();
        check("clear_count", cnt4, 0);
        check("clear_empty", empty4, 1);
        check("clear_af", af4, 0);

        // mid-stream reset
        for (int i = 0; i < 3; i++) begin
            wr4 = 1'b1; d4 = 32'hC1 + 32'(i);
            tick();
        end
        rst = 1'b0; d4 = 32'hC4;
        tick();
        rst = 1'b1; wr4 = 1'b0;
        check("rst_mid_count", cnt4, 0);
        check("rst_mid_empty", empty4, 1);
        check("rst_mid_full", full4, 0);

        wr4 = 1'b1; d4 = 32'hD1;
        tick();
        wr4 = 1'b0;
        check("post_rst_q", q4, 32'hD1);
        check("post_rst_count", cnt4, 1);
        rd4 = 1'b1;
        tick();
        rd4 = 1'b0;
        check("post_rst_empty", empty4, 1);

        // random legal traffic on DEPTH=2 and DEPTH=5
        for (int i = 0; i < 10000; i++) begin
            wr2 = !full2 && ($urandom_range(0, 1) == 1);
            rd2 = !empty2 && ($urandom_range(0, 1) == 1);
            d2  = 16'($urandom);
            wr5 = !full5 && ($urandom_range(0, 2) != 0);
            rd5 = !empty5 && ($urandom_range(0, 1) == 1);
            d5  = 16'($urandom);
            if (rd2) check("rnd2_q", q2, sb2.pop_front());
            if (rd5) check("rnd5_q", q5, sb5.pop_front());
            if (wr2) sb2.push_back(d2);
            if (wr5) sb5.push_back(d5);
            tick();
            check("rnd2_count", cnt2, sb2.size());
            check("rnd2_flags", {empty2, full2, af2},
                  {sb2.size() == 0, sb2.size() == 2, sb2.size() >= 1});
            check("rnd5_count", cnt5, sb5.size());
            check("rnd5_flags", {empty5, full5, af5},
                  {sb5.size() == 0, sb5.size() == 5, sb5.size() >= 2});
        end
        wr2 = 1'b0; rd2 = 1'b0; wr5 = 1'b0; rd5 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
